// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - multiplexed common-anode 7-segment driver for a packed BCD frame
module bcd_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic                  lzb,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  bad_code
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                bad_q, bad_d;

  logic                tick, boundary, accept;
  logic                zero_above;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_digit;
  logic                cur_blank;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign in_ready = !pending_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign bad_code = bad_q;

  // Refresh divider, digit scan and frame hand-over from shadow to display at the frame boundary.
  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    boundary  = tick && (idx_q == IDX_MAX);
    accept    = in_valid && !pending_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    // A pending frame blocks acceptance, so transfer and accept never coincide.
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = in_bcd;
      pending_d = 1'b1;
    end
  end

  // Leading-zero mask: a digit blanks when it and every more significant digit are zero.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above && (disp_q[4*i +: 4] == 4'd0);
      blank_vec[i] = (i != 0) && lzb && zero_above;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_blank = blank_vec[i];
      end
    end
  end

  // Next output value: anodes off during the anti-ghosting window, else one anode low.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    bad_d = 1'b0;
    if (cnt_q >= BLANK_C) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = cur_blank ? 7'h7F : seg_decode(cur_digit);
      bad_d = !cur_blank && (cur_digit > 4'd9);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      bad_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      bad_q     <= bad_d;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - randomized self-checking bench for bcd_seg_scan
module tb_bcd_seg_scan;

  localparam int D = 4;
  localparam int R = 4;
  localparam int B = 1;
  localparam int FRAME = D * R;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_bcd = 16'h0;
  logic         lzb = 1'b0;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         bad_code;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: time since reset, frame registers and expected outputs.
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  logic        m_pending = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_bad = 1'b0;
  logic [6:0]  dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                            7'h7F, 7'h7F};
  int          mc, mi, md, mrest;
  logic        mblank, macc;
  logic [12:0] obs, expv;

  bcd_seg_scan #(.DIGITS(D), .REFRESH_DIV(R), .BLANK(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bcd   (in_bcd),
    .lzb      (lzb),
    .an       (an),
    .seg      (seg),
    .bad_code (bad_code)
  );

  always #5 clk = ~clk;

  // Behavioural model: slot and digit derived arithmetically from elapsed cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_bad = 1'b0;
    end else begin
      mc     = m_t % R;
      mi     = (m_t / R) % D;
      mrest  = int'(m_disp) >> (4 * mi);
      md     = mrest & 15;
      mblank = lzb && (mi > 0) && (mrest == 0);
      if (mc < B) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_bad = 1'b0;
      end else begin
        exp_an  = ~(4'b0001 << mi);
        exp_seg = mblank ? 7'h7F : dec[md];
        exp_bad = (md > 9);
      end
      macc = in_valid && !m_pending;
      if ((m_t % FRAME) == FRAME - 1 && m_pending) begin
        m_disp = m_shadow; m_pending = 1'b0;
      end
      if (macc) begin
        m_shadow = in_bcd; m_pending = 1'b1;
      end
      m_t++;
    end
  end

  task automatic send(input logic [15:0] f);
    in_valid = 1'b1; in_bcd = f;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (7) @(negedge clk);
    send(16'h9999);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pre_ready got %b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, bad_code, in_ready} !== {4'hF, 7'h7F, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_async got %b_%b_%b_%b want 1111_1111111_0_1", an, seg, bad_code, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_first_blank an got %b want 1111", an); end
    @(negedge clk);
    n_checks++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      n_fail++; $display("FAIL reset_first_digit got %b_%b want 1110_1000000", an, seg);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL reset_scan t=%0d got %b want %b", m_t, obs, expv); end
    end
  endtask

  task automatic test_digits;
    bit ok;
    lzb = 1'b0;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL digits_wait in_ready got 0 want 1"); end
    send(16'h1234);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL digits_ready_low got %b want 0", in_ready); end
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL digits_scan t=%0d got %b want %b", m_t, obs, expv); end
    end
  endtask

  task automatic test_lzb;
    bit ok;
    lzb = 1'b1;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lzb_wait in_ready got 0 want 1"); end
    send(16'h0070);
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (k == 3 * FRAME) lzb = 1'b0;
      @(negedge clk);
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL lzb_scan t=%0d got %b want %b", m_t, obs, expv); end
    end
  endtask

  task automatic test_bad_code;
    bit ok;
    int nbad;
    lzb = 1'b0;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bad_wait in_ready got 0 want 1"); end
    send(16'h00A5);
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL bad_scan t=%0d got %b want %b", m_t, obs, expv); end
    end
    nbad = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (bad_code) begin
        nbad++;
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'h7F}) begin
          n_fail++; $display("FAIL bad_slot got %b_%b want 1101_1111111", an, seg);
        end
      end
    end
    n_checks++;
    if (nbad != R - B) begin n_fail++; $display("FAIL bad_count got %0d want %0d", nbad, R - B); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit seen;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_wait in_ready got 0 want 1"); end
    in_valid = 1'b1; in_bcd = 16'h1111;
    @(negedge clk);
    in_bcd = 16'h2222;
    seen = 1'b0;
    for (int k = 0; k < 2 * FRAME + 2 && !seen; k++) begin
      @(negedge clk);
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL b2b_hold t=%0d got %b want %b", m_t, obs, expv); end
      if (in_ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_ready_return got 0 want 1"); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept ready got %b want 0", in_ready); end
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL b2b_scan t=%0d got %b want %b", m_t, obs, expv); end
    end
  endtask

  task automatic test_boundary_accept;
    bit ok;
    wait_ready(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bnd_wait in_ready got 0 want 1"); end
    for (int k = 0; k < FRAME + 1 && (m_t % FRAME) != FRAME - 1; k++) @(negedge clk);
    send(16'h8086);
    for (int k = 1; k <= FRAME + 1; k++) begin
      n_checks++;
      if (in_ready !== (k == FRAME + 1)) begin
        n_fail++; $display("FAIL bnd_ready k=%0d got %b want %b", k, in_ready, (k == FRAME + 1));
      end
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL bnd_scan t=%0d got %b want %b", m_t, obs, expv); end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [15:0] f;
    for (int k = 0; k < 1500; k++) begin
      obs = {an, seg, bad_code, in_ready}; expv = {exp_an, exp_seg, exp_bad, ~m_pending};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL rand_scan t=%0d got %b want %b", m_t, obs, expv); end
      f = 16'($urandom);
      for (int d = 3; d >= 1; d--) if ($urandom_range(1, 0) == 1) f[4*d +: 4] = 4'h0;
      in_bcd   = f;
      in_valid = ($urandom_range(3, 0) == 0);
      if ($urandom_range(31, 0) == 0) lzb = ~lzb;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_digits();
    test_lzb();
    test_bad_code();
    test_back_to_back();
    test_boundary_accept();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
